// File: rtl/apb_uart_rx.sv
// apb_uart_rx: 8N1 LSB-first UART receiver. It oversamples the serial line and
// stores complete bytes in a small FIFO. Cores pop bytes through DATA (addr 0)
// and read or clear flags through STATUS (addr 1) on a zero-wait-state APB slave.
module apb_uart_rx #(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 rx_irq
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchronizer
  logic rxMeta_q;
  logic rxs_q;

  // Receive FSM
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic          pushReq_q;
  logic [7:0]    pushByte_q;
  logic          frameErr_q;

  // FIFO and flags
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [NW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;
  logic          rxIrq_q;

  // Bus decode
  logic       apbAccess;
  logic       dataRead;
  logic       statusWrite;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       pop;
  logic       pushOk;
  logic [7:0] statusByte;
  logic       unusedBits;

  assign apbAccess   = S_PSELx & S_PENABLE;
  assign dataRead    = apbAccess & ~S_PWRITE & ~S_PADDR[0];
  assign statusWrite = apbAccess & S_PWRITE & S_PADDR[0];
  assign fifoEmpty   = (count_q == '0);
  assign fifoFull    = (count_q == DEPTH_N);
  assign pop         = dataRead & ~fifoEmpty;
  // A full FIFO still accepts a byte when the same cycle frees a slot.
  assign pushOk      = pushReq_q & (~fifoFull | pop);
  assign statusByte  = {4'(count_q), ferr_q, overrun_q, fifoFull, ~fifoEmpty};
  assign S_PREADY    = apbAccess;
  assign rx_irq      = rxIrq_q;
  assign unusedBits  = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

  // Bring the asynchronous serial line into the clk domain; idle level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rx_wire;
      rxs_q    <= rxMeta_q;
    end
  end

  // Frame the synchronized line: confirm the start bit at mid-bit, then sample each bit one period apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      pushReq_q  <= 1'b0;
      pushByte_q <= '0;
      frameErr_q <= 1'b0;
    end else begin
      pushReq_q  <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= rxs_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q             <= '0;
            shift_q[bitIdx_q] <= rxs_q;
            if (bitIdx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              pushReq_q  <= 1'b1;
              pushByte_q <= shift_q;
              state_q    <= ST_IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Next-state pointers, count and sticky flags; a hardware set beats a same-cycle W1C.
  always_comb begin
    wrPtr_d   = pushOk ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d   = pop ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d   = count_q;
    case ({pushOk, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overrun_d = (pushReq_q & ~pushOk) | (overrun_q & ~(statusWrite & S_PWDATA[2]));
    ferr_d    = frameErr_q | (ferr_q & ~(statusWrite & S_PWDATA[3]));
  end

  // FIFO bookkeeping, flags and the interrupt line; reset flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      rxIrq_q   <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      rxIrq_q   <= ~fifoEmpty;
    end
  end

  // FIFO storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= pushByte_q;
    end
  end

  // Read mux: DATA shows the head (0 when empty), STATUS shows the flags; 0 when not selected.
  always_comb begin
    S_PRDATA = '0;
    if (S_PSELx && !S_PWRITE) begin
      if (!S_PADDR[0]) begin
        if (!fifoEmpty) begin
          S_PRDATA = {{(BUS_WIDTH-8){1'b0}}, mem_q[rdPtr_q]};
        end
      end else begin
        S_PRDATA = {{(BUS_WIDTH-8){1'b0}}, statusByte};
      end
    end
  end

endmodule
